// File: rtl/sensor_counter_n.sv
// Debounced event counter with up/down terminal count,
// sticky done flag and a freezable display copy.
module sensor_counter_n #(
  parameter int WIDTH   = 5,
  parameter int TARGET  = 20,
  parameter int DEB_CYC = 2_500_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sensor,
  input  logic             start,
  input  logic             hold,
  input  logic             dir,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] disp,
  output logic             done,
  output logic             done_pulse
);

  localparam int DW = $clog2(DEB_CYC);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYC - 1);
  localparam logic [WIDTH-1:0] TOP = WIDTH'(TARGET);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  logic          s_meta_q;
  logic          s_sync_q;
  logic [DW-1:0] deb_cnt_q;
  logic [DW-1:0] deb_cnt_d;
  logic          sens_db_q;
  logic          sens_db_d;
  logic          db_prev_q;
  logic          rise_q;

  state_t           state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] disp_q;
  logic             done_q;
  logic             done_pulse_q;

  logic [WIDTH-1:0] preset;
  logic [WIDTH-1:0] end_val;
  logic [WIDTH-1:0] step;

  // Level is accepted only after DEB_CYC consecutive mismatching cycles.
  always_comb begin
    deb_cnt_d = deb_cnt_q;
    sens_db_d = sens_db_q;
    if (s_sync_q == sens_db_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DEB_MAX) begin
      deb_cnt_d = '0;
      sens_db_d = s_sync_q;
    end else begin
      deb_cnt_d = deb_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_meta_q  <= 1'b0;
      s_sync_q  <= 1'b0;
      deb_cnt_q <= '0;
      sens_db_q <= 1'b0;
      db_prev_q <= 1'b0;
      rise_q    <= 1'b0;
    end else begin
      s_meta_q  <= sensor;
      s_sync_q  <= s_meta_q;
      deb_cnt_q <= deb_cnt_d;
      sens_db_q <= sens_db_d;
      db_prev_q <= sens_db_q;
      rise_q    <= sens_db_q & ~db_prev_q;
    end
  end

  always_comb begin
    preset  = dir ? TOP : '0;
    end_val = dir ? '0 : TOP;
    step    = count_q;
    if (dir) begin
      if (count_q != '0) step = count_q - 1'b1;
    end else begin
      if (count_q < TOP) step = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      disp_q       <= '0;
      done_q       <= 1'b0;
      done_pulse_q <= 1'b0;
    end else begin
      done_pulse_q <= 1'b0;
      if (!hold) disp_q <= count_q;
      unique case (state_q)
        IDLE: begin
          count_q <= preset;
          done_q  <= 1'b0;
          if (start) state_q <= RUN;
        end
        RUN: begin
          if (!start) begin
            state_q <= IDLE;
            count_q <= preset;
            done_q  <= 1'b0;
          end else if (rise_q) begin
            count_q <= step;
            if (step == end_val) begin
              state_q      <= DONE;
              done_q       <= 1'b1;
              done_pulse_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (!start) begin
            state_q <= IDLE;
            count_q <= preset;
            done_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign count      = count_q;
  assign disp       = disp_q;
  assign done       = done_q;
  assign done_pulse = done_pulse_q;

endmodule

// File: doc/sensor_counter_n.md
SENSOR_COUNTER_N -- requirements
Module: sensor_counter_n

Interface
REQ-001 The block SHALL have parameter WIDTH, default 5, count and display width in bits.
REQ-002 The block SHALL have parameter TARGET, default 20, terminal count, and SHALL require TARGET < 2^WIDTH.
REQ-003 The block SHALL have parameter DEB_CYC, default 2_500_000, the debounce stability window in clk cycles, with DEB_CYC >= 2.
REQ-004 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset for all state.
REQ-006 sensor  input  1  raw, asynchronous, bouncing event sensor; one event is one debounced 0->1 transition.
REQ-007 start  input  1  run enable; low holds the counter at its preset.
REQ-008 hold  input  1  freezes the display output only; counting SHALL continue.
REQ-009 dir  input  1  0 = count up from 0 to TARGET, 1 = count down from TARGET to 0.
REQ-010 count  output  WIDTH  live event count.
REQ-011 disp  output  WIDTH  display copy of count, frozen while hold = 1.
REQ-012 done  output  1  sticky terminal-count flag; also serves as the buzzer enable.
REQ-013 done_pulse  output  1  one-cycle strobe in the cycle done first rises.

Function
REQ-014 sensor SHALL pass through a two-flop synchronizer to form s_sync.
REQ-015 A debounce counter SHALL clear whenever s_sync equals the debounced level sens_db. Otherwise it SHALL increment.
REQ-016 When the debounce counter reaches DEB_CYC-1 with s_sync != sens_db, sens_db SHALL take s_sync and the counter SHALL clear. A level must therefore be stable for DEB_CYC consecutive cycles before it is accepted.
REQ-017 rise SHALL be a registered one-cycle pulse, asserted in the cycle after sens_db goes 0->1. A 1->0 transition SHALL produce no event.
REQ-018 The state machine SHALL have three states: IDLE, RUN and DONE. Reset SHALL enter IDLE.
REQ-019 IDLE: count SHALL equal (dir ? TARGET : 0) every cycle and done SHALL be 0. The machine SHALL go to RUN on the first cycle start = 1.
REQ-020 RUN, on rise with dir = 0: count SHALL become count+1 in the next cycle.
REQ-021 RUN, on rise with dir = 1: count SHALL become count-1 in the next cycle.
REQ-022 RUN: when the value written to count equals the end value (TARGET when up, 0 when down), the machine SHALL go to DONE. done SHALL be 1 in the same cycle that count shows the end value.
REQ-023 DONE: count SHALL saturate at the end value and further rise pulses SHALL be ignored.
REQ-024 done_pulse SHALL be high only in the first DONE cycle.
REQ-025 In RUN or DONE, start = 0 SHALL return the machine to IDLE on the next edge. count SHALL take its preset and done SHALL clear. This takes priority over rise.
REQ-026 A change of dir while in RUN SHALL change only the direction of later steps. count SHALL NOT be reloaded.
REQ-027 Counting SHALL never wrap: the up direction never exceeds TARGET and the down direction never goes below 0.
REQ-028 disp SHALL load count every cycle while hold = 0 and SHALL retain its value while hold = 1. Its latency is one cycle after count.
REQ-029 hold SHALL have no effect on count, done or state.
REQ-030 The latency from a clean sensor rise to the count change SHALL be 2 (sync) + DEB_CYC + 1 (rise) + 1 cycles.

Reset
REQ-031 Asserting reset SHALL immediately force count = 0, disp = 0, done = 0, done_pulse = 0, state IDLE, sens_db = 0, synchronizer flops = 0 and debounce counter = 0.
REQ-032 After reset releases, in IDLE, count SHALL show the preset for the current dir.
REQ-033 Reset asserted mid-debounce or mid-count SHALL discard all pending events.

Verification (DEB_CYC = 4, WIDTH = 5, TARGET = 20)
REQ-034 The bench SHALL cover: start = 1, dir = 0, 20 clean sensor pulses each 10 cycles high and 10 low -> count steps 1..20, done = 1 and done_pulse high for 1 cycle at count = 20; a 21st pulse leaves count = 20.
REQ-035 The bench SHALL cover: a 3-cycle sensor glitch and bouncing 1-cycle toggles -> count unchanged; a 6-cycle-stable high -> exactly +1.
REQ-036 The bench SHALL cover: count = 7, hold = 1, 3 pulses -> count = 10, disp = 7; hold = 0 -> disp = 10 one cycle later.
REQ-037 The bench SHALL cover: dir = 1, start = 1, 20 pulses -> count 19..0, done = 1 at 0; then start = 0 -> count = 20 and done = 0 next cycle.
REQ-038 The bench SHALL cover: reset pulsed asynchronously between clk edges at count = 12 -> all outputs 0 before the next edge; no count change from the interrupted pulse.
REQ-039 The bench SHALL cover: start dropped in the same cycle as rise at count = 5 -> count returns to preset and the event is not counted.
